dmem_ctrl: RTL

Parametrised data-memory controller replacing the single-cycle combinational data RAM behind the processor's LDR/STR path. It accepts one load/store request at a time over a valid/ready handshake and supports word and byte (LDRB/STRB) access. Read/write latency is configurable, and misaligned or out-of-range accesses are flagged. It sits between the processor's memory stage and the data RAM array.

---
 rtl/dmem_pkg.sv | 29 ++
 rtl/dmem_array.sv | 36 +++
 rtl/dmem_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory controller: FSM state encoding,
// word geometry constants and byte-lane insert/extract.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   localparam int WORD_BYTES = 4;
   localparam int LAT_MAX    = 8;

   // Place byte b into lane `lane` of word, leaving the other lanes untouched.
   function automatic logic [31:0] lane_insert(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [7:0]  b);
      logic [31:0] r;
      r = word;
      r[lane*8 +: 8] = b;
      return r;
   endfunction

   function automatic logic [7:0] lane_extract(input logic [31:0] word,
                                               input logic [1:0]  lane);
      return word[lane*8 +: 8];
   endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH_WORDS x 32 synchronous RAM, one 8-bit bank per byte lane so each lane
// has its own write enable; read is registered and read-first.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 64,
   parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic                  clk,
   input  logic                  re,
   input  logic [WORD_BYTES-1:0] we,
   input  logic [IDX_W-1:0]      addr,
   input  logic [31:0]           wdata,
   output logic [31:0]           rdata
);

   generate
      for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
         logic [7:0] mem [DEPTH_WORDS];
         logic [7:0] q_reg;

         // Non-blocking read and write on the same edge: q_reg sees the old byte.
         always_ff @(posedge clk) begin
            if (re) begin
               q_reg <= mem[addr];
            end
            if (we[gi]) begin
               mem[addr] <= wdata[gi*8 +: 8];
            end
         end

         assign rdata[gi*8 +: 8] = q_reg;
      end
   endgenerate

endmodule

// File: rtl/dmem_ctrl.sv
// Load/store data-memory controller with valid/ready request, fixed LAT-cycle
// response, word/byte access and error flagging. Define DMEM_STATS_EN for counters.
module dmem_ctrl
   import dmem_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int DEPTH_WORDS = 64,
   parameter int LAT         = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic              req_byte,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err
`ifdef DMEM_STATS_EN
   ,
   output logic [31:0]       stat_loads,
   output logic [31:0]       stat_stores,
   output logic [31:0]       stat_errs
`endif
);

   localparam int              IDX_W      = $clog2(DEPTH_WORDS);
   localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(DEPTH_WORDS * WORD_BYTES);
   localparam logic [2:0]      CNT_INIT   = 3'((LAT > 1) ? LAT - 2 : 0);

   state_t              state_reg, state_next;
   logic [2:0]          cnt_reg, cnt_next;
   logic [ADDR_W-1:0]   addr_reg;
   logic [DATA_W-1:0]   wdata_reg;
   logic                we_reg;
   logic                byte_reg;

   logic                resp_err_reg;
   logic                resp_load_reg;
   logic                resp_byte_reg;
   logic [1:0]          resp_lane_reg;

   logic                accept;
   logic                go_resp;
   logic                use_live;

   logic [ADDR_W-1:0]   acc_addr;
   logic [DATA_W-1:0]   acc_wdata;
   logic                acc_we;
   logic                acc_byte;
   logic                acc_err;
   logic [1:0]          acc_lane;
   logic [IDX_W-1:0]    acc_idx;

   logic                ram_re;
   logic [WORD_BYTES-1:0] ram_we;
   logic [31:0]         ram_wdata;
   logic [31:0]         ram_rdata;

   assign req_ready = (state_reg != WAIT);
   assign accept    = req_valid && req_ready;

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      go_resp    = 1'b0;
      use_live   = 1'b0;
      case (state_reg)
         IDLE, RESP: begin
            if (accept) begin
               if (LAT == 1) begin
                  state_next = RESP;
                  go_resp    = 1'b1;
                  use_live   = 1'b1;
               end else begin
                  state_next = WAIT;
                  cnt_next   = CNT_INIT;
               end
            end else begin
               state_next = IDLE;
            end
         end
         WAIT: begin
            if (cnt_reg == 3'd0) begin
               state_next = RESP;
               go_resp    = 1'b1;
            end else begin
               cnt_next = cnt_reg - 3'd1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // With LAT=1 the access happens on the accepting edge, so it uses the live request.
   assign acc_addr  = use_live ? req_addr  : addr_reg;
   assign acc_wdata = use_live ? req_wdata : wdata_reg;
   assign acc_we    = use_live ? req_we    : we_reg;
   assign acc_byte  = use_live ? req_byte  : byte_reg;
   assign acc_lane  = acc_addr[1:0];
   assign acc_idx   = acc_addr[IDX_W+1:2];
   assign acc_err   = (!acc_byte && (acc_lane != 2'b00)) || ({1'b0, acc_addr} >= ADDR_LIMIT);

   // rst gating keeps a request presented during reset from touching the RAM.
   assign ram_re    = go_resp && !rst;
   assign ram_we    = (go_resp && !rst && acc_we && !acc_err)
                    ? (acc_byte ? (4'b0001 << acc_lane) : 4'hF)
                    : 4'h0;
   assign ram_wdata = acc_byte ? lane_insert(32'h0, acc_lane, acc_wdata[7:0]) : acc_wdata;

   dmem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (IDX_W)
   ) u_array (
      .clk   (clk),
      .re    (ram_re),
      .we    (ram_we),
      .addr  (acc_idx),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         cnt_reg       <= 3'd0;
         addr_reg      <= '0;
         wdata_reg     <= '0;
         we_reg        <= 1'b0;
         byte_reg      <= 1'b0;
         resp_err_reg  <= 1'b0;
         resp_load_reg <= 1'b0;
         resp_byte_reg <= 1'b0;
         resp_lane_reg <= 2'b00;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         if (accept) begin
            addr_reg  <= req_addr;
            wdata_reg <= req_wdata;
            we_reg    <= req_we;
            byte_reg  <= req_byte;
         end
         if (go_resp) begin
            resp_err_reg  <= acc_err;
            resp_load_reg <= !acc_we && !acc_err;
            resp_byte_reg <= acc_byte;
            resp_lane_reg <= acc_lane;
         end
      end
   end

   // The RAM output register only updates on entry to RESP, so this holds between responses.
   assign resp_valid = (state_reg == RESP);
   assign resp_err   = resp_valid && resp_err_reg;
   assign resp_rdata = !resp_load_reg ? '0
                     : resp_byte_reg  ? {24'h0, lane_extract(ram_rdata, resp_lane_reg)}
                     : ram_rdata;

`ifdef DMEM_STATS_EN
   logic [31:0] loads_reg, stores_reg, errs_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         loads_reg  <= 32'h0;
         stores_reg <= 32'h0;
         errs_reg   <= 32'h0;
      end else if (go_resp) begin
         if (acc_err) begin
            if (errs_reg != 32'hFFFF_FFFF) errs_reg <= errs_reg + 32'd1;
         end else if (acc_we) begin
            if (stores_reg != 32'hFFFF_FFFF) stores_reg <= stores_reg + 32'd1;
         end else begin
            if (loads_reg != 32'hFFFF_FFFF) loads_reg <= loads_reg + 32'd1;
         end
      end
   end

   assign stat_loads  = loads_reg;
   assign stat_stores = stores_reg;
   assign stat_errs   = errs_reg;
`endif

endmodule
